// File: rtl/alu_pkg.sv
// Shared definitions for the pipelined ALU.
// Contents:
//   - OP_*        : 3-bit opcodes carried on alu_sel
//   - state_t     : handshake FSM state encoding (IDLE / MUL / HOLD)
//   - add_sub_of  : signed overflow for add/sub, computed from the sign bits
package alu_pkg;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SLL = 3'b011;
  localparam logic [2:0] OP_MUL = 3'b100;
  localparam logic [2:0] OP_SRL = 3'b101;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,  // no result held
    ST_MUL  = 2'd1,  // Booth multiplier iterating
    ST_HOLD = 2'd2   // result valid, waiting for the consumer
  } state_t;

  // For sub the effective second operand is ~b, so its sign is flipped.
  // Overflow means both effective operands share a sign the result lacks.
  function automatic logic add_sub_of(input logic is_sub,
                                      input logic a_msb,
                                      input logic b_msb,
                                      input logic r_msb);
    return (a_msb == (b_msb ^ is_sub)) && (r_msb != a_msb);
  endfunction

endpackage

// File: rtl/booth_mul_seq.sv
// Sequential radix-2 Booth multiplier, signed x signed, one bit per cycle.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset (aborts a run)
//   start      : load operands and begin WIDTH iterations
//   a, b       : multiplicand, multiplier (two's complement)
//   done       : high during the last iteration cycle
//   product    : 2*WIDTH signed product, valid while done is high
//                (it is the combinational result of the final iteration, so
//                the caller can capture it on the same edge)
module booth_mul_seq #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int SHW = $clog2(WIDTH);

  // The accumulator and multiplicand carry one extra sign bit so that
  // subtracting the most-negative multiplicand cannot overflow.
  logic [WIDTH:0]   acc;
  logic [WIDTH:0]   mcand;
  logic [WIDTH-1:0] mq;
  logic             q_m1;
  logic [SHW-1:0]   cnt;
  logic             running;

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   acc_nxt;
  logic [WIDTH-1:0] mq_nxt;

  // NOTE: every signal written here gets a value on every path first, so no
  // latch is inferred.
  always_comb begin
    sum = acc;
    case ({mq[0], q_m1})
      2'b01:   sum = acc + mcand;
      2'b10:   sum = acc - mcand;
      default: sum = acc;
    endcase
    // Arithmetic right shift of the {acc, mq, q_m1} chain.
    acc_nxt = {sum[WIDTH], sum[WIDTH:1]};
    mq_nxt  = {sum[0], mq[WIDTH-1:1]};
  end

  assign done    = running && (cnt == SHW'(WIDTH - 1));
  // The true product always fits in 2*WIDTH bits; the extra sign bit drops.
  assign product = {acc_nxt[WIDTH-1:0], mq_nxt};

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc     <= '0;
      mcand   <= '0;
      mq      <= '0;
      q_m1    <= 1'b0;
      cnt     <= '0;
      running <= 1'b0;
    end else if (start) begin
      acc     <= '0;
      mcand   <= {a[WIDTH-1], a};
      mq      <= b;
      q_m1    <= 1'b0;
      cnt     <= '0;
      running <= 1'b1;
    end else if (running) begin
      acc  <= acc_nxt;
      mq   <= mq_nxt;
      q_m1 <= mq[0];
      cnt  <= cnt + SHW'(1);
      if (done) running <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_pipe.sv
// Handshaked ALU stage between register read and writeback.
// Single-cycle ops are registered (latency 1); mul runs a WIDTH-cycle Booth
// iteration and returns a 2*WIDTH signed product.
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   in_valid, in_ready  : operand-side handshake
//   a, b, alu_sel       : operands and opcode (shift amount is b[SHW-1:0])
//   out_valid, out_ready: result-side handshake
//   result, result_hi   : result (mul: low/high product halves; hi=0 otherwise)
//   of                  : signed overflow for add/sub/mul, 0 otherwise
//   busy                : multiply iteration in progress
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       alu_sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             of,
  output logic             busy
);

  state_t state, state_nxt;

  logic                 accept;
  logic                 is_mul;
  logic                 mul_done;
  logic [2*WIDTH-1:0]   mul_product;

  logic [WIDTH-1:0]     op_res;
  logic                 op_of;
  logic [WIDTH-1:0]     sum;
  logic [WIDTH-1:0]     diff;

  logic [WIDTH-1:0]     res_q;
  logic [WIDTH-1:0]     hi_q;
  logic                 of_q;

  assign is_mul = (alu_sel == OP_MUL);
  assign accept = in_valid && in_ready;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept) state_nxt = is_mul ? ST_MUL : ST_HOLD;
      ST_MUL:  if (mul_done) state_nxt = ST_HOLD;
      ST_HOLD: begin
        // An accept here replaces the held result as if coming from IDLE.
        if (accept)         state_nxt = is_mul ? ST_MUL : ST_HOLD;
        else if (out_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == ST_IDLE) || ((state == ST_HOLD) && out_ready);
    out_valid = (state == ST_HOLD);
    busy      = (state == ST_MUL);
  end

  // ------------------------------------------------- single-cycle datapath
  assign sum  = a + b;
  assign diff = a + ~b + WIDTH'(1);

  always_comb begin
    op_res = '0;
    op_of  = 1'b0;
    case (alu_sel)
      OP_AND: op_res = a & b;
      OP_OR:  op_res = a | b;
      OP_ADD: begin
        op_res = sum;
        op_of  = add_sub_of(1'b0, a[WIDTH-1], b[WIDTH-1], sum[WIDTH-1]);
      end
      OP_SUB: begin
        op_res = diff;
        op_of  = add_sub_of(1'b1, a[WIDTH-1], b[WIDTH-1], diff[WIDTH-1]);
      end
      OP_SLL: op_res = a << b[SHW-1:0];
      OP_SRL: op_res = a >> b[SHW-1:0];
      OP_SLT: op_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      default: op_res = '0;  // mul goes through the Booth unit
    endcase
  end

  // --------------------------------------------------------- multiplier
  booth_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (accept && is_mul),
    .a       (a),
    .b       (b),
    .done    (mul_done),
    .product (mul_product)
  );

  // ------------------------------------------------------ output registers
  // NOTE: these are plain datapath registers (not a memory array), so they
  // are reset to give the defined zero outputs after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_q <= '0;
      hi_q  <= '0;
      of_q  <= 1'b0;
    end else if (accept && !is_mul) begin
      res_q <= op_res;
      hi_q  <= '0;
      of_q  <= op_of;
    end else if (mul_done) begin
      res_q <= mul_product[WIDTH-1:0];
      hi_q  <= mul_product[2*WIDTH-1:WIDTH];
      // Overflow when the high half is not just the sign of the low half.
      of_q  <= |(mul_product[2*WIDTH-1:WIDTH] ^ {WIDTH{mul_product[WIDTH-1]}});
    end
  end

  assign result    = res_q;
  assign result_hi = hi_q;
  assign of        = of_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe at WIDTH=32: directed vectors with literal
// expectations plus a scoreboard fed by an arithmetic reference model.
module tb_alu_pipe;
  import alu_pkg::*;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic [2:0]    alu_sel = 3'b000;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [W-1:0]  result;
  logic [W-1:0]  result_hi;
  logic          of;
  logic          busy;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [W-1:0] lo;
    logic [W-1:0] hi;
    logic         ovf;
  } exp_t;

  exp_t sb[$];

  alu_pipe #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .alu_sel   (alu_sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .result_hi (result_hi),
    .of        (of),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: plain integer arithmetic on 64-bit signed values.
  function automatic exp_t model(input logic [2:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t   e;
    longint sx, sy, p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    e.lo = '0; e.hi = '0; e.ovf = 1'b0;
    p = 0;
    case (op)
      OP_AND: e.lo = x & y;
      OP_OR:  e.lo = x | y;
      OP_ADD: begin p = sx + sy; e.lo = p[W-1:0]; e.ovf = (p > 64'sh7FFFFFFF) || (p < -64'sh80000000); end
      OP_SUB: begin p = sx - sy; e.lo = p[W-1:0]; e.ovf = (p > 64'sh7FFFFFFF) || (p < -64'sh80000000); end
      OP_SLL: e.lo = x << (y % W);
      OP_SRL: e.lo = x >> (y % W);
      OP_SLT: e.lo = (sx < sy) ? 1 : 0;
      OP_MUL: begin
        p = sx * sy;
        e.lo = p[W-1:0];
        e.hi = p[2*W-1:W];
        e.ovf = (p > 64'sh7FFFFFFF) || (p < -64'sh80000000);
      end
      default: e.lo = '0;
    endcase
    return e;
  endfunction

  // Scoreboard: all observation happens at the falling edge, where inputs
  // and outputs are stable for the next rising edge.
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
    end else begin
      if (out_valid) begin
        if (sb.size() == 0) begin
          check("out_valid_with_nothing_pending", out_valid, 1'b0);
        end else begin
          check("sb_result",    result,    sb[0].lo);
          check("sb_result_hi", result_hi, sb[0].hi);
          check("sb_of",        of,        sb[0].ovf);
          if (out_ready) void'(sb.pop_front());
        end
      end
      if (in_valid && in_ready) sb.push_back(model(alu_sel, a, b));
    end
  end

  // Present an op and keep it until accepted (bounded).
  task automatic issue(input logic [2:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
    bit got;
    int n;
    alu_sel = op; a = x; b = y; in_valid = 1'b1;
    got = 1'b0; n = 0;
    while (!got && n < 100) begin
      @(negedge clk);
      got = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!got) check("accept_timeout", got, 1'b1);
  endtask

  task automatic wait_out(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check(name, out_valid, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int stale;

    // ---------------------------------------------------------- reset
    #1 rst = 1'b1;
    #2;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_busy",      busy,      1'b0);
    check("rst_result",    result,    '0);
    check("rst_result_hi", result_hi, '0);
    check("rst_of",        of,        1'b0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", in_ready, 1'b1);
    @(posedge clk); #1;

    // ------------------------------------------- add overflow, latency 1
    issue(OP_ADD, 32'h7FFFFFFF, 32'h1);
    in_valid = 1'b0;
    @(negedge clk);
    check("add_valid",  out_valid, 1'b1);
    check("add_result", result,    32'h80000000);
    check("add_of",     of,        1'b1);
    check("add_hi",     result_hi, '0);
    @(posedge clk); #1;

    // --------------------------------------- back-to-back sub, slt, sll
    issue(OP_SUB, 32'h80000000, 32'h1);
    alu_sel = OP_SLT; a = 32'hFFFFFFFF; b = 32'h1;
    @(negedge clk);
    check("sub_result", result, 32'h7FFFFFFF);
    check("sub_of",     of,     1'b1);
    check("b2b_ready",  in_ready, 1'b1);
    @(posedge clk); #1;
    alu_sel = OP_SLL; a = 32'h1; b = 32'd35;
    @(negedge clk);
    check("slt_valid",  out_valid, 1'b1);
    check("slt_result", result,    32'h1);
    check("slt_of",     of,        1'b0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("sll_valid",  out_valid, 1'b1);
    check("sll_result", result,    32'h8);
    @(posedge clk); #1;

    // ------------------------------------------------ mul -3 * 7 timing
    issue(OP_MUL, 32'hFFFFFFFD, 32'd7);
    in_valid = 1'b1; alu_sel = OP_ADD;  // must be ignored while multiplying
    for (int i = 1; i <= W; i++) begin
      @(negedge clk);
      check("mul_busy",      busy,      1'b1);
      check("mul_in_ready",  in_ready,  1'b0);
      check("mul_out_valid", out_valid, 1'b0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(negedge clk);
    check("mul_valid_at_33", out_valid, 1'b1);
    check("mul_lo", result,    32'hFFFFFFEB);
    check("mul_hi", result_hi, 32'hFFFFFFFF);
    check("mul_of", of,        1'b0);
    check("mul_busy_done", busy, 1'b0);
    @(posedge clk); #1;

    // -------------------------------------------------- min * min
    issue(OP_MUL, 32'h80000000, 32'h80000000);
    in_valid = 1'b0;
    wait_out("minmin_valid");
    check("minmin_lo", result,    32'h0);
    check("minmin_hi", result_hi, 32'h40000000);
    check("minmin_of", of,        1'b1);
    @(posedge clk); #1;

    // a few extra signed products for the scoreboard
    issue(OP_MUL, 32'h7FFFFFFF, 32'h80000000); in_valid = 1'b0; wait_out("mul2_valid");
    @(posedge clk); #1;
    issue(OP_MUL, 32'h12345678, 32'hFFFF0001); in_valid = 1'b0; wait_out("mul3_valid");
    @(posedge clk); #1;
    issue(OP_AND, 32'hF0F0F0F0, 32'h3C3C3C3C);
    issue(OP_OR,  32'hF0F0F0F0, 32'h0F000F00);
    issue(OP_SRL, 32'h80000000, 32'hFFFFFFFF);
    in_valid = 1'b0;
    @(negedge clk);
    check("srl_result", result, 32'h1);
    @(posedge clk); #1;

    // ---------------------------------------------------- backpressure
    out_ready = 1'b0;
    issue(OP_ADD, 32'd5, 32'd6);
    alu_sel = OP_ADD; a = 32'd1; b = 32'd2;  // in_valid still high
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_result",   result,    32'hB);
      check("bp_valid",    out_valid, 1'b1);
      check("bp_in_ready", in_ready,  1'b0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_ready", in_ready, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("bp_new_valid",  out_valid, 1'b1);
    check("bp_new_result", result,    32'h3);
    @(posedge clk); #1;

    // ------------------------------------------- async reset mid-mul
    issue(OP_MUL, 32'd123, 32'd456);
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_out_valid", out_valid, 1'b0);
    check("arst_busy",      busy,      1'b0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("arst_in_ready",   in_ready,  1'b1);
    check("arst_out_valid2", out_valid, 1'b0);
    stale = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    check("no_stale_product", stale, 0);
    @(posedge clk); #1;
    issue(OP_ADD, 32'd1, 32'd1);
    in_valid = 1'b0;
    @(negedge clk);
    check("post_arst_add", result, 32'd2);
    @(posedge clk); #1;

    repeat (3) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
